// File: rtl/bp_pkg.sv
// Shared types and constants for the 2-bit branch predictor.
package bp_pkg;

  localparam int PC_W          = 32;
  localparam int IDX_W_DEFAULT = 6;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

endpackage

// File: rtl/sat_counter_2bit.sv
// Saturating next-state function for one 2-bit direction counter.
module sat_counter_2bit
  import bp_pkg::*;
(
  input  ctr_e state_i,
  input  logic taken_i,
  output ctr_e state_o
);

  always_comb begin
    // NOTE: default assignment first so no path leaves state_o unassigned (no latch).
    state_o = state_i;
    unique case (state_i)
      SNT: state_o = taken_i ? WNT : SNT;
      WNT: state_o = taken_i ? WT  : SNT;
      WT:  state_o = taken_i ? ST  : WNT;
      ST:  state_o = taken_i ? ST  : WT;
      default: state_o = state_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor_2bit.sv
// Direct-mapped, tagged 2-bit branch predictor with BTB target and mispredict detection.
// Optional BP_STATS_EN macro builds saturating branch / mispredict counters.
module branch_predictor_2bit
  import bp_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [PC_W-1:0] pc_f_i,
  output logic            pred_taken_o,
  output logic [PC_W-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [PC_W-1:0] upd_pc_i,
  input  logic [PC_W-1:0] upd_target_i,
  input  logic [PC_W-1:0] upd_pred_target_i,
  input  logic            upd_taken_i,
  input  logic            upd_pred_taken_i,
  output logic            mispredict_o,
  output logic [PC_W-1:0] redirect_pc_o,
  output logic [PC_W-1:0] stat_branches_o,
  output logic [PC_W-1:0] stat_mispred_o
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = PC_W - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  ctr_e             ctr_q    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             f_hit, u_hit;
  ctr_e             ctr_d;

  // Fetch lookup reads the registered table only: a same-cycle update is not visible.
  assign f_idx         = pc_f_i[IDX_W+1:2];
  assign f_hit         = valid_q[f_idx] && (tag_q[f_idx] == pc_f_i[PC_W-1:IDX_W+2]);
  assign pred_taken_o  = f_hit && ctr_q[f_idx][1];
  assign pred_target_o = pred_taken_o ? target_q[f_idx] : pc_f_i + 32'd4;

  assign u_idx = upd_pc_i[IDX_W+1:2];
  assign u_tag = upd_pc_i[PC_W-1:IDX_W+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  sat_counter_2bit u_sat (
    .state_i (ctr_q[u_idx]),
    .taken_i (upd_taken_i),
    .state_o (ctr_d)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        // NOTE: non-blocking (<=) for all sequential state so every flop samples pre-edge values.
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WNT;
      end
    end else if (upd_valid_i) begin
      valid_q[u_idx] <= 1'b1;
      if (u_hit) ctr_q[u_idx] <= ctr_d;
      else       ctr_q[u_idx] <= upd_taken_i ? WT : WNT;
    end
  end

  // NOTE: tag/target storage is not reset; valid_q masks it, keeping it plain RAM.
  always_ff @(posedge clk_i) begin
    if (!rst_i && upd_valid_i) begin
      if (!u_hit)                tag_q[u_idx]    <= u_tag;
      if (!u_hit || upd_taken_i) target_q[u_idx] <= upd_target_i;
    end
  end

  assign mispredict_o  = upd_valid_i &&
                         ((upd_taken_i != upd_pred_taken_i) ||
                          (upd_taken_i && (upd_target_i != upd_pred_target_i)));
  assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + 32'd4;

`ifdef BP_STATS_EN
  logic [PC_W-1:0] branches_q, mispred_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branches_q <= '0;
      mispred_q  <= '0;
    end else begin
      if (upd_valid_i && (branches_q != '1)) branches_q <= branches_q + 32'd1;
      if (mispredict_o && (mispred_q != '1)) mispred_q  <= mispred_q + 32'd1;
    end
  end

  assign stat_branches_o = branches_q;
  assign stat_mispred_o  = mispred_q;
`else
  assign stat_branches_o = '0;
  assign stat_mispred_o  = '0;
`endif

endmodule
